fir_mac_param: RTL and testbench

- Parametrised sequential FIR filter for the FM receiver datapath (channel filter / audio LPF): one sample in, one filtered sample out per ap_start transaction.
- Next-generation operator for this datapath, with these changes:
  - tap count, data width and coefficient width are generic;
  - the delay line is an internal circular buffer;
  - one MAC runs per cycle, instead of one per four cycles;
  - the output is rounded and saturated, not truncated;
  - a self-flush clears history after reset.
- Coefficients come from an external single-port ROM with 1-cycle read latency.

---
 rtl/fir_pkg.sv | 45 ++++
 rtl/fir_delay_line.sv | 53 +++++
 rtl/fir_mac_param.sv | 176 +++++++++++++++++
 tb/tb_fir_mac_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, defaults and arithmetic helpers for the parametrised FIR MAC.
// Optional build macro: FIR_SYMMETRIC_EN (used by the top and the delay line).
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_FRAC_W = 14;
  localparam int DEF_NTAPS  = 73;
  localparam int DEF_ACC_W  = 40;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int DEF_ADDR_W = clog2(DEF_NTAPS);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_DONE
  } fir_state_e;

  // Round half up, arithmetic shift, then clamp to the signed data_w range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                    input int unsigned frac_w,
                                                    input int unsigned data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac_w > 0) r = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store with one write port, async read port(s) and the post-reset flush counter.
// The second read port exists only when FIR_SYMMETRIC_EN is defined.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  output logic                     flush_last_o,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]        raddr0_i,
  output logic signed [DATA_W-1:0] rdata0_o
`ifdef FIR_SYMMETRIC_EN
  ,
  input  logic [ADDR_W-1:0]        raddr1_i,
  output logic signed [DATA_W-1:0] rdata1_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

  logic signed [DATA_W-1:0] mem_q [NTAPS];
  logic [ADDR_W-1:0]        fcnt_q, fcnt_d;

  always_comb begin
    flush_last_o = (fcnt_q == LAST);
    fcnt_d       = fcnt_q;
    if (flush_i) fcnt_d = flush_last_o ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  // Flush has priority; the FSM never requests a sample write while flushing.
  always_ff @(posedge clk_i) begin
    if (flush_i)   mem_q[fcnt_q]  <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
`ifdef FIR_SYMMETRIC_EN
  assign rdata1_o = mem_q[raddr1_i];
`endif

endmodule

// File: rtl/fir_mac_param.sv
// Sequential FIR: one sample per ap_start, one MAC per cycle, rounded and saturated output.
// Build macro FIR_SYMMETRIC_EN folds symmetric taps into ceil(NTAPS/2) MAC cycles.
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  input  logic [DATA_W-1:0]        x_V,
  output logic [ADDR_W-1:0]        coeff_V_address0,
  output logic                     coeff_V_ce0,
  input  logic [COEF_W-1:0]        coeff_V_q0,
  output logic [DATA_W-1:0]        ap_return
);

`ifdef FIR_SYMMETRIC_EN
  localparam int MAC_LEN = (NTAPS + 1) / 2;
  localparam int X_W     = DATA_W + 1;
  localparam logic [ADDR_W:0] NT_M1 = (ADDR_W+1)'(NTAPS - 1);
`else
  localparam int MAC_LEN = NTAPS;
  localparam int X_W     = DATA_W;
`endif
  localparam int P_W = X_W + COEF_W;
  localparam logic [ADDR_W:0]   NT       = (ADDR_W+1)'(NTAPS);
  localparam logic [ADDR_W-1:0] NT_LAST  = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] MAC_LAST = ADDR_W'(MAC_LEN - 1);

  fir_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        k_q, k_d, base_q, base_d, wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [X_W-1:0]    x_q, x_d;
  logic signed [P_W-1:0]    prod_q, prod_d;
  logic                     v1_q, v2_q;
  logic [DATA_W-1:0]        ret_q, ret_d;

  logic                     dl_flush, dl_flush_last, dl_we;
  logic [ADDR_W-1:0]        rd_addr0;
  logic signed [DATA_W-1:0] rd_data0;
`ifdef FIR_SYMMETRIC_EN
  logic [ADDR_W-1:0]        rd_addr1;
  logic signed [DATA_W-1:0] rd_data1;
  logic [ADDR_W:0]          mirror;
`endif

  // (b - d) mod NTAPS, with d in [0, NTAPS-1]
  function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W:0] d);
    logic [ADDR_W:0] t;
    if ({1'b0, b} >= d) t = {1'b0, b} - d;
    else                t = {1'b0, b} + NT - d;
    return t[ADDR_W-1:0];
  endfunction

  fir_delay_line #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk_i        (ap_clk),
    .rst_i        (ap_rst),
    .flush_i      (dl_flush),
    .flush_last_o (dl_flush_last),
    .we_i         (dl_we),
    .waddr_i      (wr_ptr_q),
    .wdata_i      (x_V),
    .raddr0_i     (rd_addr0),
    .rdata0_o     (rd_data0)
`ifdef FIR_SYMMETRIC_EN
    ,
    .raddr1_i     (rd_addr1),
    .rdata1_o     (rd_data1)
`endif
  );

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    base_d           = base_q;
    wr_ptr_d         = wr_ptr_q;
    acc_d            = v2_q ? acc_q + ACC_W'(prod_q) : acc_q;
    ret_d            = ret_q;
    dl_flush         = 1'b0;
    dl_we            = 1'b0;
    ap_idle          = 1'b0;
    ap_done          = 1'b0;
    coeff_V_ce0      = 1'b0;
    coeff_V_address0 = '0;
    prod_d           = $signed(coeff_V_q0) * x_q;

    rd_addr0 = wrap_sub(base_q, {1'b0, k_q});
`ifdef FIR_SYMMETRIC_EN
    mirror   = NT_M1 - {1'b0, k_q};
    rd_addr1 = wrap_sub(base_q, mirror);
    x_d      = (mirror == {1'b0, k_q}) ? X_W'(rd_data0)
                                       : X_W'(rd_data0) + X_W'(rd_data1);
`else
    x_d      = rd_data0;
`endif

    case (state_q)
      ST_FLUSH: begin
        dl_flush = 1'b1;
        if (dl_flush_last) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) begin
          dl_we   = 1'b1;
          base_d  = wr_ptr_q;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        coeff_V_ce0      = 1'b1;
        coeff_V_address0 = k_q;
        k_d              = k_q + 1'b1;
        if (k_q == MAC_LAST) state_d = ST_DRAIN1;
      end
      ST_DRAIN1: state_d = ST_DRAIN2;
      // Result is registered here from the final accumulation so it is stable during DONE.
      ST_DRAIN2: begin
        ret_d   = DATA_W'(sat_round(64'(acc_d), FRAC_W, DATA_W));
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ap_done  = 1'b1;
        wr_ptr_d = (base_q == NT_LAST) ? '0 : base_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase
    ap_ready = ap_done;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= ST_FLUSH;
      k_q      <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      prod_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      wr_ptr_q <= wr_ptr_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      prod_q   <= prod_d;
      v1_q     <= (state_q == ST_MAC);
      v2_q     <= v1_q;
      ret_q    <= ret_d;
    end
  end

  assign ap_return = ret_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// Directed bench for fir_mac_param: a 73-tap raw-integer instance and a 4-tap Q14 instance.
module tb_fir_mac_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        start1 = 1'b0, done1, idle1, ready1, ce1;
  logic [15:0] x1 = '0, q1 = '0, ret1;
  logic [6:0]  addr1;
  logic [15:0] rom1 [128];

  logic        start2 = 1'b0, done2, idle2, ready2, ce2;
  logic [15:0] x2 = '0, q2 = '0, ret2;
  logic [1:0]  addr2;
  logic [15:0] rom2 [4];

  always @(posedge clk) if (ce1) q1 <= rom1[addr1];
  always @(posedge clk) if (ce2) q2 <= rom2[addr2];

  fir_mac_param #(.DATA_W(16), .COEF_W(16), .FRAC_W(0), .NTAPS(73), .ACC_W(40), .ADDR_W(7)) dut1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start1), .ap_done(done1), .ap_idle(idle1),
    .ap_ready(ready1), .x_V(x1), .coeff_V_address0(addr1), .coeff_V_ce0(ce1),
    .coeff_V_q0(q1), .ap_return(ret1));

  fir_mac_param #(.DATA_W(16), .COEF_W(16), .FRAC_W(14), .NTAPS(4), .ACC_W(40), .ADDR_W(2)) dut2 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start2), .ap_done(done2), .ap_idle(idle2),
    .ap_ready(ready2), .x_V(x2), .coeff_V_address0(addr2), .coeff_V_ce0(ce2),
    .coeff_V_q0(q2), .ap_return(ret2));

  // One transaction on dut1; n = edges from accept edge to the edge that raises ap_done.
  task automatic run1(input logic [15:0] x, output logic [15:0] y, output int n, output bit ok);
    ok = 1'b0; y = '0; n = 0;
    for (int i = 0; i < 300 && !idle1; i++) begin @(posedge clk); #1; end
    x1 = x; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done1) begin n = i; y = ret1; ok = 1'b1; break; end
    end
  endtask

  task automatic run2(input logic [15:0] x, output logic [15:0] y, output int n, output bit ok);
    ok = 1'b0; y = '0; n = 0;
    for (int i = 0; i < 300 && !idle2; i++) begin @(posedge clk); #1; end
    x2 = x; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done2) begin n = i; y = ret2; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int  f1, f2;
    bit  saw_done;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({idle1, done1, ready1, ce1} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {idle1, done1, ready1, ce1}); end
    tests++; if (ret1 !== 16'h0000) begin
      fails++; $display("FAIL reset_ret: got %h expected 0000", ret1); end
    rst = 1'b0;
    f1 = 0; f2 = 0; saw_done = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done1 || done2) saw_done = 1'b1;
      if (idle1 && f1 == 0) f1 = i;
      if (idle2 && f2 == 0) f2 = i;
      if (f1 != 0 && f2 != 0) break;
    end
    tests++; if (f1 != 73) begin
      fails++; $display("FAIL flush_len73: idle rose after %0d edges expected 73", f1); end
    tests++; if (f2 != 4) begin
      fails++; $display("FAIL flush_len4: idle rose after %0d edges expected 4", f2); end
    tests++; if (saw_done) begin
      fails++; $display("FAIL flush_no_done: got done=1 expected 0"); end
    tests++; if (ret1 !== 16'h0000) begin
      fails++; $display("FAIL flush_ret: got %h expected 0000", ret1); end
  endtask

  task automatic test_rounding();
    logic [15:0] xv [8] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003, 16'hFFFD};
    logic [15:0] cv [8] = '{16'h4000, 16'h1FFF, 16'h2000, 16'h6000, 16'h7FFF, 16'h7FFF, 16'h2000, 16'h2000};
    logic [15:0] ev [8] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF};
    logic [15:0] y;
    int n;
    bit ok;
    rom2[1] = '0; rom2[2] = '0; rom2[3] = '0;
    for (int i = 0; i < 8; i++) begin
      rom2[0] = cv[i];
      run2(xv[i], y, n, ok);
      tests++; if (!ok || y !== ev[i]) begin
        fails++; $display("FAIL round[%0d]: got %h expected %h (done=%0d)", i, y, ev[i], ok); end
      tests++; if (n != 6) begin
        fails++; $display("FAIL round_lat[%0d]: got %0d expected 6", i, n); end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] y, e;
    int n;
    bit ok;
    for (int k = 0; k < 128; k++) rom1[k] = (k < 73) ? 16'(k + 1) : 16'h0000;
    for (int j = 0; j < 74; j++) begin
      run1((j == 0) ? 16'h0001 : 16'h0000, y, n, ok);
      e = (j < 73) ? 16'(j + 1) : 16'h0000;
      tests++; if (!ok || y !== e) begin
        fails++; $display("FAIL impulse[%0d]: got %h expected %h (done=%0d)", j, y, e, ok); end
      tests++; if (n != 75) begin
        fails++; $display("FAIL impulse_lat[%0d]: got %0d expected 75", j, n); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_y [3] = '{16'd1, 16'd3, 16'd6};
    int last, d;
    bit rdy_ok;
    for (int i = 0; i < 300 && !idle1; i++) begin @(posedge clk); #1; end
    x1 = 16'h0001; start1 = 1'b1;
    d = 0; last = 0; rdy_ok = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        if (!ready1) rdy_ok = 1'b0;
        tests++; if (ret1 !== exp_y[d]) begin
          fails++; $display("FAIL b2b_val[%0d]: got %h expected %h", d, ret1, exp_y[d]); end
        if (d > 0) begin
          tests++; if (i - last != 77) begin
            fails++; $display("FAIL b2b_gap[%0d]: got %0d expected 77", d, i - last); end
        end
        last = i; d++;
        if (d == 3) begin start1 = 1'b0; break; end
      end
    end
    start1 = 1'b0;
    tests++; if (d != 3) begin
      fails++; $display("FAIL b2b_count: got %0d dones expected 3", d); end
    tests++; if (!rdy_ok) begin
      fails++; $display("FAIL b2b_ready: got ready=0 with done expected 1"); end
  endtask

  task automatic test_ignore_busy();
    int n1, cnt;
    logic [15:0] y;
    for (int i = 0; i < 300 && !idle1; i++) begin @(posedge clk); #1; end
    x1 = 16'h0000; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n1 = 0; cnt = 0; y = '0;
    for (int i = 1; i <= 160; i++) begin
      if (i == 10) begin x1 = 16'd100; start1 = 1'b1; end
      if (i == 11) start1 = 1'b0;
      @(posedge clk); #1;
      if (done1) begin cnt++; if (n1 == 0) begin n1 = i; y = ret1; end end
    end
    tests++; if (cnt != 1 || n1 != 75) begin
      fails++; $display("FAIL busy_ignore: got %0d dones first at %0d expected 1 at 75", cnt, n1); end
    tests++; if (y !== 16'd9) begin
      fails++; $display("FAIL busy_val: got %h expected 0009", y); end
  endtask

  task automatic test_saturation();
    logic [15:0] y;
    int n;
    bit ok, bad;
    for (int k = 0; k < 128; k++) rom1[k] = (k < 73) ? 16'h7FFF : 16'h0000;
    bad = 1'b0;
    for (int j = 0; j < 73; j++) begin
      run1(16'h7FFF, y, n, ok);
      if (!ok || y !== 16'h7FFF) bad = 1'b1;
    end
    tests++; if (bad || y !== 16'h7FFF) begin
      fails++; $display("FAIL sat_pos: got %h expected 7fff (all)", y); end
    for (int j = 0; j < 73; j++) begin
      run1(16'h8000, y, n, ok);
      if (j == 0) begin
        tests++; if (y !== 16'h7FFF) begin
          fails++; $display("FAIL sat_mix: got %h expected 7fff", y); end
      end
    end
    tests++; if (!ok || y !== 16'h8000) begin
      fails++; $display("FAIL sat_neg: got %h expected 8000", y); end
  endtask

  task automatic test_reset_mid_mac();
    bit saw_done;
    for (int i = 0; i < 300 && !idle1; i++) begin @(posedge clk); #1; end
    x1 = 16'h0001; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin @(posedge clk); #1; if (done1) saw_done = 1'b1; end
    tests++; if (ce1 !== 1'b1) begin
      fails++; $display("FAIL midmac_busy: got ce=%b expected 1", ce1); end
    rst = 1'b1;
    #1;
    tests++; if (saw_done || done1 !== 1'b0 || ce1 !== 1'b0) begin
      fails++; $display("FAIL midmac_abort: got done=%b ce=%b expected 0 0", done1 | saw_done, ce1); end
    tests++; if (ret1 !== 16'h0000) begin
      fails++; $display("FAIL midmac_ret: got %h expected 0000", ret1); end
    test_reset();
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_impulse();
    test_back_to_back();
    test_ignore_busy();
    test_saturation();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
